// File: rtl/lsu_sram_if.sv
// rtl/lsu_sram_if.sv - MEM-stage load/store unit driving an SRAM-like req/addr_ok/data_ok bus
// One access per instruction: decode, lane placement, alignment faults, handshake FSM, load extract.
module lsu_sram_if #(
   parameter int ADDR_W       = 32,
   parameter bit UNALIGNED_EN = 1'b1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              mem_en,
   input  logic              mem_adv,
   input  logic              flush,
   input  logic [7:0]        op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic [31:0]       rt_old,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [3:0]        data_wstrb,
   output logic [ADDR_W-1:0] data_addr,
   output logic [31:0]       data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [31:0]       data_rdata,
   output logic [31:0]       rdata_o,
   output logic              stall_o,
   output logic              adel,
   output logic              ades,
   output logic [ADDR_W-1:0] bad_addr
);

   localparam logic [7:0] OP_LB  = 8'b1110_0000;
   localparam logic [7:0] OP_LH  = 8'b1110_0001;
   localparam logic [7:0] OP_LWL = 8'b1110_0010;
   localparam logic [7:0] OP_LW  = 8'b1110_0011;
   localparam logic [7:0] OP_LBU = 8'b1110_0100;
   localparam logic [7:0] OP_LHU = 8'b1110_0101;
   localparam logic [7:0] OP_LWR = 8'b1110_0110;
   localparam logic [7:0] OP_SB  = 8'b1110_1000;
   localparam logic [7:0] OP_SH  = 8'b1110_1001;
   localparam logic [7:0] OP_SWL = 8'b1110_1010;
   localparam logic [7:0] OP_SW  = 8'b1110_1011;
   localparam logic [7:0] OP_SWR = 8'b1110_1110;

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ABORT, S_DONE} state_t;

   state_t      state;
   logic [7:0]  op_q;
   logic [1:0]  lo_q;
   logic [31:0] rt_q;
   logic        ld_q;

   logic        is_load, is_store, start;
   logic [1:0]  lo;
   logic [4:0]  sh;
   logic [1:0]  n_size;
   logic [3:0]  n_strb;
   logic [31:0] n_wdata;
   logic [ADDR_W-1:0] n_addr;
   logic [4:0]  sh_q;
   logic [7:0]  rbyte;
   logic [15:0] rhalf;
   logic [31:0] ld_result;

   assign lo = addr[1:0];
   assign sh = {lo, 3'b000};

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      case (op)
         OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: is_load  = 1'b1;
         OP_SB, OP_SH, OP_SW:                 is_store = 1'b1;
         OP_LWL, OP_LWR:                      is_load  = UNALIGNED_EN;
         OP_SWL, OP_SWR:                      is_store = UNALIGNED_EN;
         default: ;
      endcase
   end

   assign adel = mem_en & (((op == OP_LW) & (lo != 2'b00)) |
                           (((op == OP_LH) | (op == OP_LHU)) & lo[0]));
   assign ades = mem_en & (((op == OP_SW) & (lo != 2'b00)) | ((op == OP_SH) & lo[0]));
   assign bad_addr = (adel | ades) ? addr : '0;

   assign start   = mem_en & (is_load | is_store) & ~adel & ~ades & ~flush & (state == S_IDLE);
   assign stall_o = start | (state == S_REQ) | (state == S_WAIT) | (state == S_ABORT);

   // Bus image for the access about to start; loads carry no strobes.
   always_comb begin
      n_size  = 2'd2;
      n_strb  = 4'b0000;
      n_wdata = 32'h0;
      n_addr  = addr;
      case (op)
         OP_LB, OP_LBU: n_size = 2'd0;
         OP_LH, OP_LHU: n_size = 2'd1;
         OP_LWL, OP_LWR: n_addr = {addr[ADDR_W-1:2], 2'b00};
         OP_SB: begin
            n_size  = 2'd0;
            n_strb  = 4'b0001 << lo;
            n_wdata = {4{wdata[7:0]}};
         end
         OP_SH: begin
            n_size  = 2'd1;
            n_strb  = lo[1] ? 4'b1100 : 4'b0011;
            n_wdata = {2{wdata[15:0]}};
         end
         OP_SW: begin
            n_strb  = 4'b1111;
            n_wdata = wdata;
         end
         OP_SWL: begin
            n_addr  = {addr[ADDR_W-1:2], 2'b00};
            n_strb  = 4'b1111 >> ~lo;
            n_wdata = wdata >> {~lo, 3'b000};
         end
         OP_SWR: begin
            n_addr  = {addr[ADDR_W-1:2], 2'b00};
            n_strb  = 4'b1111 << lo;
            n_wdata = wdata << sh;
         end
         default: ;
      endcase
   end

   assign sh_q  = {lo_q, 3'b000};
   assign rbyte = 8'(data_rdata >> sh_q);
   assign rhalf = lo_q[1] ? data_rdata[31:16] : data_rdata[15:0];

   always_comb begin
      ld_result = data_rdata;
      case (op_q)
         OP_LB:  ld_result = {{24{rbyte[7]}}, rbyte};
         OP_LBU: ld_result = {24'h0, rbyte};
         OP_LH:  ld_result = {{16{rhalf[15]}}, rhalf};
         OP_LHU: ld_result = {16'h0, rhalf};
         OP_LWL: ld_result = (data_rdata << {~lo_q, 3'b000}) | (rt_q & (32'h00FF_FFFF >> sh_q));
         OP_LWR: ld_result = (data_rdata >> sh_q) | (rt_q & ~(32'hFFFF_FFFF >> sh_q));
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         data_req   <= 1'b0;
         data_wr    <= 1'b0;
         data_size  <= 2'd0;
         data_wstrb <= 4'b0000;
         data_addr  <= '0;
         data_wdata <= 32'h0;
         rdata_o    <= 32'h0;
         op_q       <= 8'h0;
         lo_q       <= 2'b00;
         rt_q       <= 32'h0;
         ld_q       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               state      <= S_REQ;
               data_req   <= 1'b1;
               data_wr    <= is_store;
               data_size  <= n_size;
               data_wstrb <= n_strb;
               data_addr  <= n_addr;
               data_wdata <= n_wdata;
               op_q       <= op;
               lo_q       <= lo;
               rt_q       <= rt_old;
               ld_q       <= is_load;
            end
            // An accepted address always owes a response, even if flushed.
            S_REQ: if (data_addr_ok) begin
               data_req <= 1'b0;
               state    <= flush ? S_ABORT : S_WAIT;
            end else if (flush) begin
               data_req <= 1'b0;
               state    <= S_IDLE;
            end
            S_WAIT: if (data_data_ok) begin
               if (flush) begin
                  state <= S_IDLE;
               end else begin
                  if (ld_q) rdata_o <= ld_result;
                  state <= S_DONE;
               end
            end else if (flush) begin
               state <= S_ABORT;
            end
            S_ABORT: if (data_data_ok) state <= S_IDLE;
            S_DONE:  if (mem_adv | flush) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_sram_if.sv
// tb/tb_lsu_sram_if.sv - directed self-checking bench for lsu_sram_if
module tb_lsu_sram_if;

   localparam logic [7:0] OP_NOP = 8'b0010_0000;
   localparam logic [7:0] OP_LB  = 8'b1110_0000;
   localparam logic [7:0] OP_LH  = 8'b1110_0001;
   localparam logic [7:0] OP_LWL = 8'b1110_0010;
   localparam logic [7:0] OP_LW  = 8'b1110_0011;
   localparam logic [7:0] OP_LHU = 8'b1110_0101;
   localparam logic [7:0] OP_LWR = 8'b1110_0110;
   localparam logic [7:0] OP_SB  = 8'b1110_1000;
   localparam logic [7:0] OP_SH  = 8'b1110_1001;
   localparam logic [7:0] OP_SWL = 8'b1110_1010;
   localparam logic [7:0] OP_SW  = 8'b1110_1011;
   localparam logic [7:0] OP_SWR = 8'b1110_1110;

   logic        clk = 1'b0;
   logic        resetn, mem_en, mem_adv, flush;
   logic [7:0]  op;
   logic [31:0] addr, wdata, rt_old;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata, rdata_o;
   logic        stall_o, adel, ades;
   logic [31:0] bad_addr;

   int checks   = 0;
   int failures = 0;
   int acc_cnt  = 0;
   int acc0;

   lsu_sram_if #(.ADDR_W(32), .UNALIGNED_EN(1'b1)) dut (
      .clk(clk), .resetn(resetn), .mem_en(mem_en), .mem_adv(mem_adv), .flush(flush),
      .op(op), .addr(addr), .wdata(wdata), .rt_old(rt_old),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .rdata_o(rdata_o), .stall_o(stall_o), .adel(adel), .ades(ades), .bad_addr(bad_addr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (resetn && data_req && data_addr_ok) acc_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_access(input string tag, input logic [7:0] o, input logic [31:0] a,
                             input logic [31:0] rt, input logic [31:0] rd,
                             input int hold, input int done_hold,
                             input logic [31:0] e_addr, input logic [1:0] e_size,
                             input logic e_wr, input logic [3:0] e_strb,
                             input logic [31:0] e_wdata, input logic [31:0] e_rdata);
      int a0;
      a0 = acc_cnt;
      mem_en = 1'b1; op = o; addr = a; wdata = rt; rt_old = rt; data_rdata = rd;
      #1;
      check({tag, "_stall_start"}, stall_o, 1);
      check({tag, "_req_start"}, data_req, 0);
      step();
      for (int i = 0; i <= hold; i++) begin
         #1;
         check({tag, "_req"}, data_req, 1);
         check({tag, "_addr"}, data_addr, e_addr);
         check({tag, "_size"}, data_size, e_size);
         check({tag, "_wr"}, data_wr, e_wr);
         check({tag, "_strb"}, data_wstrb, e_strb);
         if (e_wr) check({tag, "_wdata"}, data_wdata, e_wdata);
         check({tag, "_stall_req"}, stall_o, 1);
         if (i == hold) data_addr_ok = 1'b1;
         step();
      end
      data_addr_ok = 1'b0;
      #1;
      check({tag, "_req_wait"}, data_req, 0);
      check({tag, "_stall_wait"}, stall_o, 1);
      data_data_ok = 1'b1;
      step();
      data_data_ok = 1'b0;
      #1;
      check({tag, "_stall_done"}, stall_o, 0);
      if (!e_wr) check({tag, "_rdata"}, rdata_o, e_rdata);
      check({tag, "_one_access"}, acc_cnt - a0, 1);
      for (int i = 0; i < done_hold; i++) begin
         step();
         check({tag, "_done_req"}, data_req, 0);
         check({tag, "_done_stall"}, stall_o, 0);
         check({tag, "_done_rdata"}, rdata_o, e_rdata);
      end
      check({tag, "_no_reissue"}, acc_cnt - a0, 1);
      mem_adv = 1'b1;
      step();
      mem_adv = 1'b0; mem_en = 1'b0; op = OP_NOP;
   endtask

   initial begin
      resetn = 1'b0; mem_en = 1'b0; mem_adv = 1'b0; flush = 1'b0; op = OP_NOP;
      addr = 32'h0; wdata = 32'h0; rt_old = 32'h0;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      step();
      check("rst_req", data_req, 0);
      check("rst_wr", data_wr, 0);
      check("rst_size", data_size, 0);
      check("rst_strb", data_wstrb, 0);
      check("rst_addr", data_addr, 0);
      check("rst_wdata", data_wdata, 0);
      check("rst_rdata", rdata_o, 0);
      check("rst_stall", stall_o, 0);

      run_access("lb",  OP_LB,  32'h1003, 32'h0,         32'h80FF_0000, 0, 0, 32'h1003, 2'd0, 1'b0, 4'b0000, 32'h0,         32'hFFFF_FF80);
      run_access("sh",  OP_SH,  32'h2002, 32'h1234_ABCD, 32'h0,         0, 0, 32'h2002, 2'd1, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0);

      mem_en = 1'b1; op = OP_SH; addr = 32'h2001; wdata = 32'h1234_ABCD;
      #1;
      check("sh_mis_ades", ades, 1);
      check("sh_mis_adel", adel, 0);
      check("sh_mis_bad", bad_addr, 32'h2001);
      check("sh_mis_stall", stall_o, 0);
      step();
      check("sh_mis_req", data_req, 0);
      mem_en = 1'b0; op = OP_NOP;
      #1 check("bad_clear", bad_addr, 0);

      run_access("lwl", OP_LWL, 32'h3001, 32'h1122_3344, 32'hAABB_CCDD, 0, 0, 32'h3000, 2'd2, 1'b0, 4'b0000, 32'h0,         32'hCCDD_3344);
      run_access("swr", OP_SWR, 32'h3002, 32'h1122_3344, 32'h0,         0, 0, 32'h3000, 2'd2, 1'b1, 4'b1100, 32'h3344_0000, 32'h0);
      run_access("sb",  OP_SB,  32'h5001, 32'h0000_00A5, 32'h0,         0, 0, 32'h5001, 2'd0, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0);
      run_access("swl", OP_SWL, 32'h5005, 32'h1122_3344, 32'h0,         0, 0, 32'h5004, 2'd2, 1'b1, 4'b0011, 32'h0000_1122, 32'h0);
      run_access("lwr", OP_LWR, 32'h3003, 32'h1122_3344, 32'hAABB_CCDD, 0, 0, 32'h3000, 2'd2, 1'b0, 4'b0000, 32'h0,         32'h1122_33AA);
      run_access("lhu", OP_LHU, 32'h4002, 32'h0,         32'h8765_4321, 0, 0, 32'h4002, 2'd1, 1'b0, 4'b0000, 32'h0,         32'h0000_8765);
      run_access("lh",  OP_LH,  32'h4002, 32'h0,         32'h8765_4321, 0, 0, 32'h4002, 2'd1, 1'b0, 4'b0000, 32'h0,         32'hFFFF_8765);
      run_access("lw_hold", OP_LW, 32'h4000, 32'h0,      32'hDEAD_BEEF, 5, 3, 32'h4000, 2'd2, 1'b0, 4'b0000, 32'h0,         32'hDEAD_BEEF);

      mem_en = 1'b1; op = OP_LW; addr = 32'h4001;
      #1;
      check("lw_mis_adel", adel, 1);
      check("lw_mis_bad", bad_addr, 32'h4001);
      check("lw_mis_stall", stall_o, 0);
      op = OP_NOP; addr = 32'h4000;
      #1 check("nonmem_stall", stall_o, 0);
      step();
      check("nonmem_req", data_req, 0);
      check("nonmem_rdata", rdata_o, 32'hDEAD_BEEF);
      mem_en = 1'b0;

      acc0 = acc_cnt;
      mem_en = 1'b1; op = OP_LW; addr = 32'h6000;
      step();
      check("fl_req_req", data_req, 1);
      flush = 1'b1;
      step();
      flush = 1'b0; mem_en = 1'b0; op = OP_NOP;
      #1;
      check("fl_req_drop", data_req, 0);
      check("fl_req_stall", stall_o, 0);
      step();
      check("fl_req_none", acc_cnt - acc0, 0);
      check("fl_req_rdata", rdata_o, 32'hDEAD_BEEF);

      acc0 = acc_cnt;
      mem_en = 1'b1; op = OP_LW; addr = 32'h7000;
      step();
      data_addr_ok = 1'b1;
      step();
      data_addr_ok = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0; addr = 32'h7004;
      #1;
      check("abort_stall", stall_o, 1);
      check("abort_req", data_req, 0);
      step();
      check("abort_noissue", data_req, 0);
      data_data_ok = 1'b1; data_rdata = 32'h5555_5555;
      step();
      data_data_ok = 1'b0;
      #1;
      check("abort_discard", rdata_o, 32'hDEAD_BEEF);
      check("abort_next_stall", stall_o, 1);
      step();
      check("abort_next_req", data_req, 1);
      check("abort_next_addr", data_addr, 32'h7004);
      data_addr_ok = 1'b1;
      step();
      data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h600D_600D;
      step();
      data_data_ok = 1'b0;
      #1;
      check("abort_next_rdata", rdata_o, 32'h600D_600D);
      check("abort_acc", acc_cnt - acc0, 2);
      mem_adv = 1'b1;
      step();
      mem_adv = 1'b0; mem_en = 1'b0; op = OP_NOP;

      mem_en = 1'b1; op = OP_SW; addr = 32'h9000; wdata = 32'hFFFF_FFFF;
      step();
      check("rstw_req", data_req, 1);
      check("rstw_strb", data_wstrb, 4'b1111);
      data_addr_ok = 1'b1;
      step();
      data_addr_ok = 1'b0; mem_en = 1'b0; op = OP_NOP;
      #2 resetn = 1'b0;
      #1;
      check("rstw_req0", data_req, 0);
      check("rstw_wr0", data_wr, 0);
      check("rstw_strb0", data_wstrb, 0);
      check("rstw_addr0", data_addr, 0);
      check("rstw_wdata0", data_wdata, 0);
      check("rstw_rdata0", rdata_o, 0);
      check("rstw_stall0", stall_o, 0);
      step();
      resetn = 1'b1;
      step();
      check("rstw_idle_req", data_req, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

endmodule
